// File: rtl/dlsc_axi_router_wr_scheduler.sv
// AXI router W-channel scheduler: command FIFO, beat counter, outstanding tracking.
// Optional DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN drives selects straight from an empty-FIFO push.
module dlsc_axi_router_wr_scheduler #(
    parameter int LEN      = 4,
    parameter int INPUTS   = 1,
    parameter int INPUTSB  = 1,
    parameter int OUTPUTS  = 1,
    parameter int OUTPUTSB = 1,
    parameter int DEPTH    = 8,
    parameter int MOT      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_push,
    input  logic [INPUTS-1:0]   cmd_input_onehot,
    input  logic [OUTPUTS-1:0]  cmd_output_onehot,
    input  logic [INPUTSB-1:0]  cmd_input,
    input  logic [OUTPUTSB-1:0] cmd_output,
    input  logic [LEN-1:0]      cmd_len,
    output logic [INPUTS-1:0]   cmd_full_input,
    output logic [OUTPUTS-1:0]  cmd_full_output,
    output logic                sel_valid,
    output logic [INPUTS-1:0]   sel_input_onehot,
    output logic [OUTPUTS-1:0]  sel_output_onehot,
    output logic [INPUTSB-1:0]  sel_input,
    output logic [OUTPUTSB-1:0] sel_output,
    output logic                sel_last,
    input  logic                beat
);

    localparam int PTRB = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTB = $clog2(DEPTH + 1);
    localparam int MOTB = $clog2(MOT + 1);
    localparam int EW   = INPUTS + OUTPUTS + INPUTSB + OUTPUTSB + LEN;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [PTRB-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRB-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTB-1:0]     cnt_q, cnt_d;
    logic [LEN-1:0]      bcnt_q, bcnt_d;
    logic [MOTB-1:0]     in_cnt_q  [INPUTS];
    logic [MOTB-1:0]     in_cnt_d  [INPUTS];
    logic [MOTB-1:0]     out_cnt_q [OUTPUTS];
    logic [MOTB-1:0]     out_cnt_d [OUTPUTS];

    logic [EW-1:0]       cmd_entry;
    logic [EW-1:0]       head_entry;
    logic [INPUTS-1:0]   h_in_oh;
    logic [OUTPUTS-1:0]  h_out_oh;
    logic [INPUTSB-1:0]  h_in;
    logic [OUTPUTSB-1:0] h_out;
    logic [LEN-1:0]      h_len;

    logic empty, full, bypass;
    logic pop, push_ok, wr_en, rd_en, fifo_near_full;

    assign cmd_entry = {cmd_input_onehot, cmd_output_onehot,
                        cmd_input, cmd_output, cmd_len};

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNTB'(DEPTH));

`ifdef DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN
    assign bypass = empty && cmd_push;
`else
    assign bypass = 1'b0;
`endif

    assign head_entry = bypass ? cmd_entry : mem_q[rd_ptr_q];
    assign {h_in_oh, h_out_oh, h_in, h_out, h_len} = head_entry;

    assign sel_valid         = !empty || bypass;
    assign sel_input_onehot  = h_in_oh;
    assign sel_output_onehot = h_out_oh;
    assign sel_input         = h_in;
    assign sel_output        = h_out;
    assign sel_last          = sel_valid && (bcnt_q == h_len);

    assign pop     = beat && sel_last;
    assign push_ok = cmd_push && !full;
    // A bypassed command that retires in its push cycle never occupies a slot.
    assign wr_en   = push_ok && !(bypass && pop);
    assign rd_en   = pop && !bypass;

    assign wr_ptr_d = wr_en ? wr_ptr_q + PTRB'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + PTRB'(1) : rd_ptr_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CNTB'(1);
            2'b01:   cnt_d = cnt_q - CNTB'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (sel_valid && beat) begin
            bcnt_d = pop ? '0 : bcnt_q + LEN'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            in_cnt_d[i] = in_cnt_q[i];
            case ({push_ok && cmd_input_onehot[i], pop && h_in_oh[i]})
                2'b10:   in_cnt_d[i] = in_cnt_q[i] + MOTB'(1);
                2'b01:   in_cnt_d[i] = in_cnt_q[i] - MOTB'(1);
                default: in_cnt_d[i] = in_cnt_q[i];
            endcase
        end
        for (int j = 0; j < OUTPUTS; j++) begin
            out_cnt_d[j] = out_cnt_q[j];
            case ({push_ok && cmd_output_onehot[j], pop && h_out_oh[j]})
                2'b10:   out_cnt_d[j] = out_cnt_q[j] + MOTB'(1);
                2'b01:   out_cnt_d[j] = out_cnt_q[j] - MOTB'(1);
                default: out_cnt_d[j] = out_cnt_q[j];
            endcase
        end
    end

    // The cmd_push terms cover the push already in flight from the command stage.
    assign fifo_near_full = ({1'b0, cnt_q} + (CNTB+1)'(cmd_push))
                            >= (CNTB+1)'(DEPTH);

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            cmd_full_input[i] = fifo_near_full ||
                (({1'b0, in_cnt_q[i]} +
                  (MOTB+1)'(cmd_push && cmd_input_onehot[i]))
                 >= (MOTB+1)'(MOT));
        end
        for (int j = 0; j < OUTPUTS; j++) begin
            cmd_full_output[j] = fifo_near_full ||
                (({1'b0, out_cnt_q[j]} +
                  (MOTB+1)'(cmd_push && cmd_output_onehot[j]))
                 >= (MOTB+1)'(MOT));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cmd_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            for (int i = 0; i < INPUTS; i++) begin
                in_cnt_q[i] <= '0;
            end
            for (int j = 0; j < OUTPUTS; j++) begin
                out_cnt_q[j] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            for (int i = 0; i < INPUTS; i++) begin
                in_cnt_q[i] <= in_cnt_d[i];
            end
            for (int j = 0; j < OUTPUTS; j++) begin
                out_cnt_q[j] <= out_cnt_d[j];
            end
        end
    end

endmodule

// File: tb/tb_dlsc_axi_router_wr_scheduler.sv
// Directed bench for dlsc_axi_router_wr_scheduler (4 in / 4 out, DEPTH=4, MOT=2).
module tb_dlsc_axi_router_wr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_push = 1'b0;
    logic [3:0] cmd_input_onehot = '0;
    logic [3:0] cmd_output_onehot = '0;
    logic [1:0] cmd_input = '0;
    logic [1:0] cmd_output = '0;
    logic [3:0] cmd_len = '0;
    logic [3:0] cmd_full_input;
    logic [3:0] cmd_full_output;
    logic       sel_valid;
    logic [3:0] sel_input_onehot;
    logic [3:0] sel_output_onehot;
    logic [1:0] sel_input;
    logic [1:0] sel_output;
    logic       sel_last;
    logic       beat = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    dlsc_axi_router_wr_scheduler #(
        .LEN(4), .INPUTS(4), .INPUTSB(2), .OUTPUTS(4), .OUTPUTSB(2),
        .DEPTH(4), .MOT(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_push(cmd_push),
        .cmd_input_onehot(cmd_input_onehot),
        .cmd_output_onehot(cmd_output_onehot),
        .cmd_input(cmd_input), .cmd_output(cmd_output), .cmd_len(cmd_len),
        .cmd_full_input(cmd_full_input), .cmd_full_output(cmd_full_output),
        .sel_valid(sel_valid), .sel_input_onehot(sel_input_onehot),
        .sel_output_onehot(sel_output_onehot), .sel_input(sel_input),
        .sel_output(sel_output), .sel_last(sel_last), .beat(beat)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input int i, input int o,
                         input int l, input logic b);
        cmd_push          = p;
        cmd_input         = 2'(i);
        cmd_output        = 2'(o);
        cmd_input_onehot  = 4'(1 << i);
        cmd_output_onehot = 4'(1 << o);
        cmd_len           = 4'(l);
        beat              = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick;
        tick;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", sel_valid); end
        n_cmp++; if (sel_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", sel_last); end
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL rst_full_in: got %h want 0", cmd_full_input); end
        n_cmp++; if (cmd_full_output !== 4'h0) begin n_bad++; $display("FAIL rst_full_out: got %h want 0", cmd_full_output); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        drive(1, 1, 2, 3, 0);
        #1;
`ifndef DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL basic_push_valid: got %b want 0", sel_valid); end
`endif
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL basic_full_in: got %h want 0", cmd_full_input); end
        tick;
        drive(0, 1, 2, 3, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid[%0d]: got %b want 1", k, sel_valid); end
            n_cmp++; if (sel_input !== 2'd1) begin n_bad++; $display("FAIL basic_in[%0d]: got %0d want 1", k, sel_input); end
            n_cmp++; if (sel_output !== 2'd2) begin n_bad++; $display("FAIL basic_out[%0d]: got %0d want 2", k, sel_output); end
            n_cmp++; if (sel_input_onehot !== 4'b0010) begin n_bad++; $display("FAIL basic_in_oh[%0d]: got %b want 0010", k, sel_input_onehot); end
            n_cmp++; if (sel_output_onehot !== 4'b0100) begin n_bad++; $display("FAIL basic_out_oh[%0d]: got %b want 0100", k, sel_output_onehot); end
            n_cmp++; if (sel_last !== (k == 3)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", k, sel_last, (k == 3)); end
            tick;
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL basic_done: got %b want 0", sel_valid); end
        tick;
    endtask

    task automatic test_mot;
        drive(1, 0, 0, 0, 0);
        #1;
        n_cmp++; if (cmd_full_output !== 4'h0) begin n_bad++; $display("FAIL mot_first: got %b want 0000", cmd_full_output); end
        tick;
        drive(1, 0, 0, 0, 0);
        #1;
        n_cmp++; if (cmd_full_output !== 4'b0001) begin n_bad++; $display("FAIL mot_second_out: got %b want 0001", cmd_full_output); end
        n_cmp++; if (cmd_full_input !== 4'b0001) begin n_bad++; $display("FAIL mot_second_in: got %b want 0001", cmd_full_input); end
        tick;
        drive(0, 0, 0, 0, 1);
        #1;
        n_cmp++; if (cmd_full_output !== 4'b0001) begin n_bad++; $display("FAIL mot_held: got %b want 0001", cmd_full_output); end
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL mot_last: got %b want 1", sel_last); end
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (cmd_full_output !== 4'h0) begin n_bad++; $display("FAIL mot_release: got %b want 0000", cmd_full_output); end
        n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL mot_remaining: got %b want 1", sel_valid); end
        tick;
        drive(0, 0, 0, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL mot_drained: got %b want 0", sel_valid); end
        tick;
    endtask

    task automatic test_depth;
        int h;
        int b;
        logic [3:0] exp_full;
        for (int k = 0; k < 4; k++) begin
            drive(1, k, 3 - k, k, 0);
            #1;
            exp_full = (k == 3) ? 4'hF : 4'h0;
            n_cmp++; if (cmd_full_input !== exp_full) begin n_bad++; $display("FAIL depth_in[%0d]: got %b want %b", k, cmd_full_input, exp_full); end
            n_cmp++; if (cmd_full_output !== exp_full) begin n_bad++; $display("FAIL depth_out[%0d]: got %b want %b", k, cmd_full_output, exp_full); end
            tick;
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (cmd_full_input !== 4'hF) begin n_bad++; $display("FAIL depth_full_in: got %b want 1111", cmd_full_input); end
        tick;
        drive(0, 0, 0, 0, 1);
        h = 0;
        b = 0;
        repeat (10) begin
            #1;
            exp_full = (h == 0 && b == 0) ? 4'hF : 4'h0;
            n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid h%0d b%0d: got %b want 1", h, b, sel_valid); end
            n_cmp++; if (sel_input !== 2'(h)) begin n_bad++; $display("FAIL drain_in h%0d b%0d: got %0d want %0d", h, b, sel_input, h); end
            n_cmp++; if (sel_output !== 2'(3 - h)) begin n_bad++; $display("FAIL drain_out h%0d b%0d: got %0d want %0d", h, b, sel_output, 3 - h); end
            n_cmp++; if (sel_last !== (b == h)) begin n_bad++; $display("FAIL drain_last h%0d b%0d: got %b want %b", h, b, sel_last, (b == h)); end
            n_cmp++; if (cmd_full_output !== exp_full) begin n_bad++; $display("FAIL drain_full h%0d b%0d: got %b want %b", h, b, cmd_full_output, exp_full); end
            if (b == h) begin
                h++;
                b = 0;
            end else begin
                b++;
            end
            tick;
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", sel_valid); end
        tick;
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 1, 1, 0);
        tick;
        drive(0, 0, 1, 0, 1);
        #1;
        n_cmp++; if (sel_last !== 1'b0) begin n_bad++; $display("FAIL b2b_first_beat: got %b want 0", sel_last); end
        tick;
        drive(1, 0, 1, 0, 1);
        #1;
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL b2b_pop_last: got %b want 1", sel_last); end
        n_cmp++; if (cmd_full_input !== 4'b0001) begin n_bad++; $display("FAIL b2b_pop_full_in: got %b want 0001", cmd_full_input); end
        n_cmp++; if (cmd_full_output !== 4'b0010) begin n_bad++; $display("FAIL b2b_pop_full_out: got %b want 0010", cmd_full_output); end
        tick;
        drive(0, 0, 1, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_next_valid: got %b want 1", sel_valid); end
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL b2b_next_last: got %b want 1", sel_last); end
        n_cmp++; if (sel_output !== 2'd1) begin n_bad++; $display("FAIL b2b_next_out: got %0d want 1", sel_output); end
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL b2b_in_cnt: got %b want 0000", cmd_full_input); end
        tick;
        drive(1, 0, 1, 0, 1);
        #1;
        n_cmp++; if (cmd_full_input !== 4'b0001) begin n_bad++; $display("FAIL b2b_probe_in: got %b want 0001", cmd_full_input); end
        tick;
        drive(0, 0, 1, 0, 1);
        #1;
        n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_nogap_valid: got %b want 1", sel_valid); end
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL b2b_nogap_last: got %b want 1", sel_last); end
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", sel_valid); end
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL b2b_empty_full: got %b want 0000", cmd_full_input); end
        tick;
    endtask

    task automatic test_reset_mid;
        drive(1, 2, 3, 7, 0);
        tick;
        drive(1, 2, 3, 7, 0);
        #1;
        n_cmp++; if (cmd_full_output !== 4'b1000) begin n_bad++; $display("FAIL rmid_full_out: got %b want 1000", cmd_full_output); end
        n_cmp++; if (cmd_full_input !== 4'b0100) begin n_bad++; $display("FAIL rmid_full_in: got %b want 0100", cmd_full_input); end
        tick;
        drive(0, 2, 3, 7, 1);
        tick;
        tick;
        rst = 1'b1;
        #1;
        n_cmp++; if (sel_last !== 1'b0) begin n_bad++; $display("FAIL rmid_beat2_last: got %b want 0", sel_last); end
        tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", sel_valid); end
        n_cmp++; if (cmd_full_output !== 4'h0) begin n_bad++; $display("FAIL rmid_clr_out: got %b want 0000", cmd_full_output); end
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL rmid_clr_in: got %b want 0000", cmd_full_input); end
        tick;
        drive(1, 1, 0, 2, 0);
        tick;
        drive(0, 1, 0, 2, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_new_valid[%0d]: got %b want 1", k, sel_valid); end
            n_cmp++; if (sel_input !== 2'd1) begin n_bad++; $display("FAIL rmid_new_in[%0d]: got %0d want 1", k, sel_input); end
            n_cmp++; if (sel_last !== (k == 2)) begin n_bad++; $display("FAIL rmid_new_last[%0d]: got %b want %b", k, sel_last, (k == 2)); end
            tick;
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", sel_valid); end
        tick;
    endtask

`ifdef DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN
    task automatic test_bypass;
        drive(1, 1, 2, 0, 1);
        #1;
        n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid: got %b want 1", sel_valid); end
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL byp_last: got %b want 1", sel_last); end
        n_cmp++; if (sel_input !== 2'd1) begin n_bad++; $display("FAIL byp_in: got %0d want 1", sel_input); end
        n_cmp++; if (sel_output !== 2'd2) begin n_bad++; $display("FAIL byp_out: got %0d want 2", sel_output); end
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL byp_empty: got %b want 0", sel_valid); end
        n_cmp++; if (cmd_full_input !== 4'h0) begin n_bad++; $display("FAIL byp_full_in: got %b want 0000", cmd_full_input); end
        n_cmp++; if (cmd_full_output !== 4'h0) begin n_bad++; $display("FAIL byp_full_out: got %b want 0000", cmd_full_output); end
        tick;
        drive(1, 3, 1, 1, 1);
        #1;
        n_cmp++; if (sel_valid !== 1'b1) begin n_bad++; $display("FAIL byp2_valid: got %b want 1", sel_valid); end
        n_cmp++; if (sel_last !== 1'b0) begin n_bad++; $display("FAIL byp2_last0: got %b want 0", sel_last); end
        tick;
        drive(0, 3, 1, 1, 1);
        #1;
        n_cmp++; if (sel_last !== 1'b1) begin n_bad++; $display("FAIL byp2_last1: got %b want 1", sel_last); end
        n_cmp++; if (sel_input !== 2'd3) begin n_bad++; $display("FAIL byp2_in: got %0d want 3", sel_input); end
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_bad++; $display("FAIL byp2_empty: got %b want 0", sel_valid); end
        tick;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_basic;
        test_mot;
        test_depth;
        test_back_to_back;
        test_reset_mid;
`ifdef DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN
        test_bypass;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dlsc_axi_router_wr_scheduler.md
# dlsc_axi_router_wr_scheduler

Write-data channel scheduler for the AXI router. It accepts routing commands pushed by the router command stage and holds them in a FIFO in issue order. It drives the W-channel mux selects for the burst at the FIFO head and counts data beats to retire each burst on its last beat. It tracks outstanding bursts per input and per output and returns `cmd_full_input` / `cmd_full_output` back-pressure to the command stage.

## Interface
Parameters:
- `LEN`, 4: AXI burst length field width; `len` = beats-1.
- `INPUTS`, 1: number of router inputs.
- `INPUTSB`, 1: width of an input index.
- `OUTPUTS`, 1: number of router outputs.
- `OUTPUTSB`, 1: width of an output index.
- `DEPTH`, 8: command FIFO entries; power of 2, ≥2.
- `MOT`, 4: maximum outstanding bursts per input and per output, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_push`  in  1  command strobe; registered in the command stage.
- `cmd_input_onehot`  in  INPUTS  source input, one-hot.
- `cmd_output_onehot`  in  OUTPUTS  destination output, one-hot.
- `cmd_input`  in  INPUTSB  source input index.
- `cmd_output`  in  OUTPUTSB  destination output index.
- `cmd_len`  in  LEN  burst length-1.
- `cmd_full_input`  out  INPUTS  per-input back-pressure.
- `cmd_full_output`  out  OUTPUTS  per-output back-pressure.
- `sel_valid`  out  1  head burst is active.
- `sel_input_onehot`  out  INPUTS  mux select, one-hot.
- `sel_output_onehot`  out  OUTPUTS  demux select, one-hot.
- `sel_input`  out  INPUTSB  mux select, index.
- `sel_output`  out  OUTPUTSB  demux select, index.
- `sel_last`  out  1  the current beat is the last beat of the head burst.
- `beat`  in  1  a data beat transferred on the selected route this cycle.

## Operation
- **FIFO.** Each entry holds {input_onehot, output_onehot, input, output, len}.
  - Occupancy `cnt` ranges 0..DEPTH.
  - Write on `cmd_push`; pop on `beat && sel_last`.
  - Simultaneous push and pop leave `cnt` unchanged.
  - Pointers wrap modulo DEPTH.
- **Head outputs.** `sel_valid` = (`cnt` != 0). All `sel_*` are taken from the head entry and are X/don't-care while `sel_valid`=0.
- **Beat counter.** `bcnt` is LEN bits, reset 0.
  - `sel_last` = `sel_valid` && (`bcnt` == head len).
  - `beat && !sel_last` → `bcnt`+1.
  - `beat && sel_last` → `bcnt`=0 and pop.
  - `beat` while `sel_valid`=0 is ignored.
- **Outstanding counters.** One counter per input and per output, each clog2(MOT+1) bits.
  - Increment on push for each set bit of the command onehot.
  - Decrement on pop for each set bit of the head onehot.
  - Push and pop on the same port in the same cycle → no change.
- **Back-pressure.**
  - `cmd_full_input[i]` = (`in_cnt[i]` + (`cmd_push` && `cmd_input_onehot[i]`)) ≥ MOT, OR (`cnt` + `cmd_push`) ≥ DEPTH.
  - `cmd_full_output` uses the same form over the output counters.
  - Both are combinational. They account for the single in-flight push caused by the command stage's registered `cmd_push`.
- **Error case.** A push when `cnt`=DEPTH is a protocol error; it is ignored and `cnt` saturates.

## Timing
- **Reset values.** `sel_valid`=0, `sel_last`=0, `cnt`=0, `bcnt`=0, all outstanding counters 0, all `cmd_full_*`=0 (when `cmd_push`=0).
- **Reset mid-burst.** All queued commands and the partial beat count are discarded.
- **Push latency (bypass off).** A push into an empty FIFO asserts `sel_valid` the next cycle.
- **Retire latency.** A pop takes effect at the clock edge of the last beat. The next entry's selects are valid the following cycle, with no bubble when the FIFO is non-empty.
- **Counter latency.** Outstanding counters update one cycle after push or pop. The `cmd_push` term covers the gap.
- **Single-beat bursts.** Back-to-back `len`=0 bursts retire one per cycle.

## Configuration
- `DLSC_AXI_ROUTER_WR_SCHED_BYPASS_EN`
  - **Defined:** when `cnt`=0 and `cmd_push`=1, `sel_valid`=1 and all `sel_*` are driven combinationally from the `cmd_*` ports in the same cycle.
    - If `beat` and `cmd_len`=0 occur in that cycle, the command retires without being written to the FIFO.
    - Otherwise it is written and becomes the head with `bcnt` already updated.
    - Outstanding counters still net to zero for a bypassed retire.
  - **Undefined:** `sel_valid` rises one cycle after the push, as described in Timing.

## Test plan
- Reset, then push input 1 / output 2 with `len`=3; assert `beat` each cycle → `sel_valid` next cycle, `sel_input`=1, `sel_output`=2, `sel_last` on the 4th beat, `sel_valid`=0 after.
- MOT=2: push 2 commands to output 0 with no beats → `cmd_full_output[0]`=1 during the 2nd push cycle and after; one retire → 0.
- DEPTH=4: push 4 commands to distinct ports → all `cmd_full_*` bits=1 while `cnt`+`cmd_push` ≥ 4; drain → `sel_*` order matches push order.
- Push with `len`=0 in the same cycle as the last-beat pop of another entry → `cnt` and shared-port counters unchanged; next head valid with no gap.
- Assert `rst` mid-burst at beat 2 of `len`=7 → `sel_valid`=0 and full bits 0 next cycle; a new push restarts at `bcnt`=0.
- BYPASS_EN: empty FIFO, push `len`=0 with `beat` in the same cycle → `sel_valid`=`sel_last`=1 that cycle, `cnt` stays 0.
